// File: rtl/hi_iso14443a_pkg.sv
// Shared ISO 14443 Type A definitions for the reader-side HF blocks:
// bit timing at fc/128, Modified Miller symbol codes and FSM state codes.
package hi_iso14443a_pkg;

  // One bit period is 128 carrier cycles (106 kbit/s); half a bit is 64.
  localparam int BIT_PERIOD = 128;
  localparam int HALF_BIT   = 64;
  localparam int CNT_W      = 7;

  // Modified Miller symbols. Y carries no pause, Z pauses at the start of
  // the bit period, X pauses at the middle.
  typedef enum logic [1:0] {
    SYM_Y = 2'd0,
    SYM_X = 2'd1,
    SYM_Z = 2'd2
  } sym_t;

  // Framing states, shared with the reader-RX decoder.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DATA = 2'd1;
  localparam logic [1:0] ST_EOF  = 2'd2;

  // Modified Miller rule: a one is always X; a zero is Y straight after a
  // one and Z otherwise.
  function automatic sym_t miller_sym(input logic bit_val, input logic prev_one);
    if (bit_val) begin
      return SYM_X;
    end
    return prev_one ? SYM_Y : SYM_Z;
  endfunction

endpackage

// File: rtl/miller_symbol_gen.sv
// Bit-period timebase and pause generator. Holds the free-running fc/128
// counter, the symbol for the current period and the registered pause.
module miller_symbol_gen
  import hi_iso14443a_pkg::*;
#(
  // Pause width in carrier cycles; legal range 16..60.
  parameter int PAUSE_LEN = 32
) (
  input  logic ck_1356meg,
  input  logic rst_n,
  input  sym_t sym_next,   // symbol for the next period, taken at a boundary
  output logic cnt_msb,    // cnt[6], high in the second half of the period
  output logic boundary,   // last cycle of the bit period (cnt == 127)
  output logic pause_q     // registered pause, lags cnt by one cycle
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] Z_END    = CNT_W'(PAUSE_LEN);
  localparam logic [CNT_W-1:0] X_START  = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] X_END    = CNT_W'(HALF_BIT + PAUSE_LEN);

  logic [CNT_W-1:0] cnt;
  sym_t             sym;
  logic             pause_d;

  assign boundary = (cnt == CNT_LAST);
  assign cnt_msb  = cnt[CNT_W-1];

  // Free-running period counter; wraps 127 -> 0 and never stops.
  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Symbol register; the new symbol covers the period that follows.
  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      sym <= SYM_Y;
    end else if (boundary) begin
      sym <= sym_next;
    end
  end

  // Pause window decode from the position within the period.
  // NOTE: pause_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pause_d = 1'b0;
    case (sym)
      SYM_Z:   pause_d = (cnt < Z_END);
      SYM_X:   pause_d = (cnt >= X_START) && (cnt < X_END);
      default: pause_d = 1'b0;
    endcase
  end

  // Registered pause, so the antenna gate is glitch-free; reset clears it
  // immediately and the carrier resumes.
  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      pause_q <= 1'b0;
    end else begin
      pause_q <= pause_d;
    end
  end

endmodule

// File: rtl/hi_reader_miller_tx.sv
// Reader-side ISO 14443 Type A transmitter. Takes the reader-to-tag
// bitstream from the ARM over SSP at fc/128, frames it (SOF, data, EOF)
// as Modified Miller and gates the 13.56 MHz drive for 100% ASK pauses.
module hi_reader_miller_tx
  import hi_iso14443a_pkg::*;
#(
  // Pause width in carrier cycles (32 = 2.36 us); legal range 16..60.
  parameter int PAUSE_LEN = 32
) (
  input  logic ck_1356meg,
  input  logic rst_n,
  input  logic ck_1356megb,
  input  logic tx_en,
  input  logic ssp_dout,
  output logic ssp_clk,
  output logic ssp_frame,
  output logic ssp_din,
  output logic pwr_hi,
  output logic pwr_lo,
  output logic pwr_oe1,
  output logic pwr_oe2,
  output logic pwr_oe3,
  output logic pwr_oe4,
  output logic dbg
);

  logic [1:0] state;
  logic [1:0] state_d;
  logic       prev_one;
  logic       prev_one_d;
  logic [2:0] bit_cnt;
  logic [2:0] bit_cnt_d;
  sym_t       sym_next;
  logic       cnt_msb;
  logic       boundary;
  logic       pause_q;

  miller_symbol_gen #(
    .PAUSE_LEN (PAUSE_LEN)
  ) u_symbol_gen (
    .ck_1356meg (ck_1356meg),
    .rst_n      (rst_n),
    .sym_next   (sym_next),
    .cnt_msb    (cnt_msb),
    .boundary   (boundary),
    .pause_q    (pause_q)
  );

  // Framing decisions for the next period; only consumed at a boundary,
  // so tx_en and ssp_dout are effectively sampled once per bit.
  always_comb begin
    state_d    = state;
    prev_one_d = prev_one;
    bit_cnt_d  = bit_cnt;
    sym_next   = SYM_Y;
    case (state)
      ST_IDLE: begin
        if (tx_en) begin
          sym_next   = SYM_Z;          // start of frame
          prev_one_d = 1'b0;
          bit_cnt_d  = 3'd0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tx_en) begin
          sym_next   = miller_sym(ssp_dout, prev_one);
          prev_one_d = ssp_dout;
          bit_cnt_d  = bit_cnt + 3'd1;
        end else begin
          sym_next   = miller_sym(1'b0, prev_one);   // end of frame: logic 0
          state_d    = ST_EOF;
        end
      end
      ST_EOF: begin
        state_d = ST_IDLE;             // trailing Y period; tx_en ignored
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Framing state advances only at bit-period boundaries.
  always_ff @(posedge ck_1356meg or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      prev_one <= 1'b0;
      bit_cnt  <= 3'd0;
    end else if (boundary) begin
      state    <= state_d;
      prev_one <= prev_one_d;
      bit_cnt  <= bit_cnt_d;
    end
  end

  // SSP towards the ARM: bit clock, byte sync and busy status.
  assign ssp_clk   = ~cnt_msb;
  assign ssp_frame = (bit_cnt == 3'd0) & ~cnt_msb;
  assign ssp_din   = (state != ST_IDLE);

  // Antenna drive: the inverted carrier, blanked during a pause.
  assign pwr_hi  = ck_1356megb & ~pause_q;
  assign pwr_lo  = 1'b0;
  assign pwr_oe1 = 1'b0;
  assign pwr_oe2 = 1'b0;
  assign pwr_oe3 = 1'b0;
  assign pwr_oe4 = 1'b0;
  assign dbg     = pause_q;

endmodule

// File: tb/tb_hi_reader_miller_tx.sv
// Bench for hi_reader_miller_tx: table of per-bit-period vectors, expected
// symbols queued when inputs are driven and compared when the period ends.
// A second instance built with PAUSE_LEN=16 receives the same stimulus.
module tb_hi_reader_miller_tx;
  import hi_iso14443a_pkg::*;

  typedef struct {
    logic tx_en;
    logic dout;
    sym_t exp_sym;     // symbol in the period after the sampling boundary
    logic exp_busy;    // ssp_din during that period
    logic exp_frame;   // ssp_frame during the first half of that period
    logic chk16;       // also check PAUSE_LEN=16 window edges
  } vec_t;

  typedef struct {
    int   period;
    vec_t v;
  } sb_t;

  logic clk;
  logic ck_1356megb;
  logic rst_n;
  logic tx_en;
  logic ssp_dout;
  logic ssp_clk, ssp_frame, ssp_din, pwr_hi, pwr_lo;
  logic pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4, dbg;
  logic ssp_clk16, ssp_frame16, ssp_din16, pwr_hi16, pwr_lo16;
  logic pwr_oe1_16, pwr_oe2_16, pwr_oe3_16, pwr_oe4_16, dbg16;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   mon_period = 0;
  logic mon_en = 1'b0;
  logic [6:0] m_cnt;
  sb_t  sb[$];
  vec_t tbl[$];

  hi_reader_miller_tx dut (
    .ck_1356meg (clk),         .rst_n (rst_n),         .ck_1356megb (ck_1356megb),
    .tx_en      (tx_en),       .ssp_dout (ssp_dout),   .ssp_clk (ssp_clk),
    .ssp_frame  (ssp_frame),   .ssp_din (ssp_din),     .pwr_hi (pwr_hi),
    .pwr_lo     (pwr_lo),      .pwr_oe1 (pwr_oe1),     .pwr_oe2 (pwr_oe2),
    .pwr_oe3    (pwr_oe3),     .pwr_oe4 (pwr_oe4),     .dbg (dbg)
  );

  hi_reader_miller_tx #(.PAUSE_LEN(16)) dut16 (
    .ck_1356meg (clk),         .rst_n (rst_n),         .ck_1356megb (ck_1356megb),
    .tx_en      (tx_en),       .ssp_dout (ssp_dout),   .ssp_clk (ssp_clk16),
    .ssp_frame  (ssp_frame16), .ssp_din (ssp_din16),   .pwr_hi (pwr_hi16),
    .pwr_lo     (pwr_lo16),    .pwr_oe1 (pwr_oe1_16),  .pwr_oe2 (pwr_oe2_16),
    .pwr_oe3    (pwr_oe3_16),  .pwr_oe4 (pwr_oe4_16),  .dbg (dbg16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  assign ck_1356megb = ~clk;

  // Reference position within the bit period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_cnt <= 7'd0;
    else        m_cnt <= m_cnt + 7'd1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout want event", name);
  endtask

  function automatic vec_t mk(input logic t, input logic d, input sym_t s,
                              input logic busy, input logic frm, input logic c16);
    vec_t v;
    v.tx_en = t; v.dout = d; v.exp_sym = s;
    v.exp_busy = busy; v.exp_frame = frm; v.chk16 = c16;
    return v;
  endfunction

  // Pause shape per symbol: Z at cnt 1..len, X at 65..64+len, Y none.
  function automatic logic [1:0] classify(input logic [127:0] p, input int len);
    logic [127:0] z, x;
    z = '0;
    x = '0;
    for (int k = 1; k <= len; k++) begin
      z[k]      = 1'b1;
      x[64 + k] = 1'b1;
    end
    if (p == '0) return SYM_Y;
    if (p == z)  return SYM_Z;
    if (p == x)  return SYM_X;
    return 2'b11;
  endfunction

  // Drive one period's inputs on the ssp_clk falling edge and queue what
  // the following period must look like.
  task automatic run_vec(input vec_t v);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_cnt != 7'd64 && n < 300);
    if (m_cnt != 7'd64) fail_timeout("drive_sync");
    tx_en    = v.tx_en;
    ssp_dout = v.dout;
    sb.push_back('{mon_period + 1, v});
  endtask

  // Monitor: capture dbg across each period and score it at cnt 127.
  initial begin : monitor
    logic [127:0] pat, pat16;
    logic         frame_s;
    sb_t          e;
    pat = '0;
    pat16 = '0;
    frame_s = 1'b0;
    forever begin
      @(negedge clk);
      if (m_cnt == 7'd0) begin
        pat = '0;
        pat16 = '0;
      end else begin
        pat[m_cnt]   = dbg;
        pat16[m_cnt] = dbg16;
      end
      if (m_cnt == 7'd32) frame_s = ssp_frame;
      if (m_cnt == 7'd127) begin
        if (mon_en) begin
          if (sb.size() != 0 && sb[0].period == mon_period) begin
            e = sb.pop_front();
            check($sformatf("sym_p%0d", mon_period), 32'(classify(pat, 32)), 32'(e.v.exp_sym));
            check($sformatf("sym16_p%0d", mon_period), 32'(classify(pat16, 16)), 32'(e.v.exp_sym));
            check($sformatf("busy_p%0d", mon_period), 32'(ssp_din), 32'(e.v.exp_busy));
            check($sformatf("frame_p%0d", mon_period), 32'(frame_s), 32'(e.v.exp_frame));
            if (e.v.chk16) begin
              check("p16_cnt64", 32'(pat16[64]), 32'd0);
              check("p16_cnt65", 32'(pat16[65]), 32'd1);
              check("p16_cnt80", 32'(pat16[80]), 32'd1);
              check("p16_cnt81", 32'(pat16[81]), 32'd0);
            end
          end else begin
            check($sformatf("idle_sym_p%0d", mon_period), 32'(classify(pat, 32)), 32'(SYM_Y));
            check($sformatf("idle_sym16_p%0d", mon_period), 32'(classify(pat16, 16)), 32'(SYM_Y));
            check($sformatf("idle_busy_p%0d", mon_period), 32'(ssp_din), 32'd0);
          end
        end
        mon_period++;
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    fail_timeout("watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int   hi_cnt, dbg_cnt, rises, last_rise, bad_gap, tgt, n;
    logic prev_sclk;

    // Vector table: REQA, single-boundary pulse, 0xFF frame.
    tbl.push_back(mk(1'b1, 1'b0, SYM_Z, 1'b1, 1'b1, 1'b0));   // REQA SOF
    tbl.push_back(mk(1'b1, 1'b0, SYM_Z, 1'b1, 1'b0, 1'b0));   // 0
    tbl.push_back(mk(1'b1, 1'b1, SYM_X, 1'b1, 1'b0, 1'b0));   // 1
    tbl.push_back(mk(1'b1, 1'b1, SYM_X, 1'b1, 1'b0, 1'b0));   // 1
    tbl.push_back(mk(1'b1, 1'b0, SYM_Y, 1'b1, 1'b0, 1'b0));   // 0 after 1
    tbl.push_back(mk(1'b1, 1'b0, SYM_Z, 1'b1, 1'b0, 1'b0));   // 0
    tbl.push_back(mk(1'b1, 1'b1, SYM_X, 1'b1, 1'b0, 1'b0));   // 1
    tbl.push_back(mk(1'b1, 1'b0, SYM_Y, 1'b1, 1'b0, 1'b0));   // 0 after 1
    tbl.push_back(mk(1'b0, 1'b0, SYM_Z, 1'b1, 1'b0, 1'b0));   // EOF 0
    tbl.push_back(mk(1'b0, 1'b0, SYM_Y, 1'b0, 1'b0, 1'b0));   // EOF Y, idle
    tbl.push_back(mk(1'b0, 1'b0, SYM_Y, 1'b0, 1'b0, 1'b0));   // idle
    tbl.push_back(mk(1'b1, 1'b0, SYM_Z, 1'b1, 1'b1, 1'b0));   // pulse SOF
    tbl.push_back(mk(1'b0, 1'b0, SYM_Z, 1'b1, 1'b1, 1'b0));   // EOF 0 after SOF
    tbl.push_back(mk(1'b0, 1'b0, SYM_Y, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, SYM_Y, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 1'b0, SYM_Z, 1'b1, 1'b1, 1'b0));   // 0xFF SOF
    tbl.push_back(mk(1'b1, 1'b1, SYM_X, 1'b1, 1'b0, 1'b1));   // first X: PAUSE_LEN=16 edges
    for (int i = 0; i < 6; i++) tbl.push_back(mk(1'b1, 1'b1, SYM_X, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, SYM_X, 1'b1, 1'b1, 1'b0));   // 8th bit, bit_cnt wraps
    tbl.push_back(mk(1'b0, 1'b0, SYM_Y, 1'b1, 1'b1, 1'b0));   // EOF 0 after 1 -> Y
    tbl.push_back(mk(1'b0, 1'b0, SYM_Y, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, SYM_Y, 1'b0, 1'b1, 1'b0));

    // Reset state.
    rst_n = 1'b0;
    tx_en = 1'b0;
    ssp_dout = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ssp_din", 32'(ssp_din), 32'd0);
    check("rst_dbg", 32'(dbg), 32'd0);
    check("rst_ssp_frame", 32'(ssp_frame), 32'd1);
    check("rst_ssp_clk", 32'(ssp_clk), 32'd1);
    check("rst_pwr_hi", 32'(pwr_hi), 32'd1);
    check("pwr_const", 32'({pwr_lo, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4}), 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Idle with tx_en low for 1000 cycles: carrier on, no pauses.
    hi_cnt = 0; dbg_cnt = 0; rises = 0; last_rise = -1; bad_gap = 0;
    prev_sclk = ssp_clk;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (pwr_hi) hi_cnt++;
      if (dbg) dbg_cnt++;
      if (ssp_clk && !prev_sclk) begin
        if (last_rise >= 0 && (i - last_rise) != 128) bad_gap++;
        last_rise = i;
        rises++;
      end
      prev_sclk = ssp_clk;
    end
    check("idle_pwr_hi_high", 32'(hi_cnt), 32'd1000);
    check("idle_no_pause", 32'(dbg_cnt), 32'd0);
    check("ssp_clk_period", 32'(bad_gap), 32'd0);
    check("ssp_clk_rises_ge7", 32'(rises >= 7), 32'd1);
    @(posedge clk);
    #1;
    check("idle_pwr_hi_low", 32'(pwr_hi), 32'd0);

    // Table-driven frames.
    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    // Reset in the middle of an X pause (cnt 70).
    run_vec(mk(1'b1, 1'b0, SYM_Z, 1'b1, 1'b1, 1'b0));
    run_vec(mk(1'b1, 1'b1, SYM_X, 1'b1, 1'b0, 1'b0));
    tgt = mon_period + 1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mon_period == tgt && m_cnt == 7'd70) && n < 400);
    if (!(mon_period == tgt && m_cnt == 7'd70)) fail_timeout("reach_cnt70");
    check("x_pause_active", 32'(dbg), 32'd1);
    check("x_pause_gates_pwr", 32'(pwr_hi), 32'd0);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_dbg", 32'(dbg), 32'd0);
    check("rst_mid_pwr_hi", 32'(pwr_hi), 32'd1);
    check("rst_mid_ssp_din", 32'(ssp_din), 32'd0);
    sb.delete();
    tx_en = 1'b0;
    ssp_dout = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    // No EOF after the abandoned frame: idle periods are checked as Y.
    repeat (3 * 128) @(negedge clk);

    // A tx_en glitch between boundaries must not start a frame.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (m_cnt != 7'd10 && n < 300);
    tx_en = 1'b1;
    repeat (5) @(negedge clk);
    tx_en = 1'b0;
    repeat (2 * 128) @(negedge clk);
    check("glitch_no_busy", 32'(ssp_din), 32'd0);

    // Drain the scoreboard.
    n = 0;
    while (sb.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) fail_timeout("sb_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hi_reader_miller_tx.md
Name: hi_reader_miller_tx

Overview:
Reader-side ISO 14443 Type A transmitter: the initiator counterpart of the tag-simulation path. It takes a reader-to-tag bitstream from the ARM over SSP at 106 kbit/s (fc/128) and encodes it as Modified Miller. It then produces 100% ASK pauses by gating the 13.56 MHz drive on pwr_hi. It sits in the HF FPGA image beside the tag-side blocks and shares the SSP pins and the ck_1356meg/ck_1356megb clocks.

Parameters:
PAUSE_LEN, 32, pause width in fc cycles (32 = 2.36 us); legal range 16..60.

Ports:
ck_1356meg  input  1  13.56 MHz system clock; all flops use the rising edge.
rst_n  input  1  asynchronous active-low reset.
ck_1356megb  input  1  inverted carrier, used only for gating the pwr_hi drive.
tx_en  input  1  ARM request; held high for the whole frame, low to end it.
ssp_dout  input  1  data bit from ARM, LSB first.
ssp_clk  output  1  bit clock, fc/128.
ssp_frame  output  1  word sync, once every 8 bit periods.
ssp_din  output  1  tx_busy status to ARM.
pwr_hi  output  1  antenna drive.
pwr_lo, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4  output  1 each  constant 0.
dbg  output  1  registered pause signal.

Behaviour:
- Clock and reset: one clock (ck_1356meg). Reset is asynchronous and active-low (rst_n).
- Reset values: cnt=0, state=IDLE, sym=Y, prev_one=0, bit_cnt=0, pause_q=0.
  - Carrier therefore runs during and immediately after reset.
  - ssp_din=0, dbg=0, ssp_frame=1, ssp_clk=1.
- cnt: 7-bit, free-running, wraps 127->0. Never stops, including in IDLE. A "boundary" is the cycle where cnt==127.
- SSP timing:
  - ssp_clk = ~cnt[6]: high for cnt 0..63, low for 64..127.
  - ARM changes ssp_dout on the ssp_clk falling edge.
  - The block samples ssp_dout and tx_en only at a boundary.
  - ssp_frame = (bit_cnt==0) & ~cnt[6].
- Symbols, indexed by cnt within the period:
  - Z: pause while cnt < PAUSE_LEN.
  - X: pause while 64 <= cnt < 64+PAUSE_LEN.
  - Y: no pause.
- pause_q: registered from the comparison on cnt and sym, so pause lags cnt by 1 cycle. pwr_hi = ck_1356megb & ~pause_q.
- FSM: all transitions, and all sym and prev_one updates, happen only at boundaries. sym applies to the following period.
  - IDLE, tx_en=1: sym=Z (SOF), prev_one=0, bit_cnt=0, go to DATA.
  - IDLE, tx_en=0: sym=Y, stay in IDLE.
  - DATA, tx_en=1: b=ssp_dout; sym = b ? X : (prev_one ? Y : Z); prev_one=b; bit_cnt++ (3-bit, wraps).
  - DATA, tx_en=0: EOF logic 0, sym = prev_one ? Y : Z; go to EOF.
  - EOF: sym=Y; go to IDLE. tx_en is ignored here.
  - Earliest restart is the boundary at the end of the EOF Y period, which is a gap of at least 1 Y period.
- ssp_din = (state != IDLE). It rises 1 cycle after the SOF boundary and falls 1 cycle after the EOF-exit boundary.
- tx_en pulse: tx_en sampled high for exactly one boundary gives SOF, then EOF. That is a 0-bit frame; it is legal.
- Reset mid-frame: pause ends at once and the frame is abandoned. No EOF is emitted.
- A tx_en glitch between boundaries has no effect.

Decomposition:
- Shared package hi_iso14443a_pkg:
  - Symbol encoding: SYM_X, SYM_Y, SYM_Z (2-bit).
  - BIT_PERIOD = 128 and HALF_BIT = 64.
  - FSM state constants, reused later by the matching reader-RX decoder.
- One natural sub-module, miller_symbol_gen: holds cnt, sym and the pause comparison. The top block keeps the FSM, SSP outputs and pwr_* assignments.

Test Plan:
- Reset released with tx_en=0 for 1000 cycles -> pwr_hi toggles continuously, ssp_din=0, no pause, ssp_clk period 128 cycles.
- REQA (7 bits, LSB first, 0,1,1,0,0,1,0; tx_en high for 8 boundaries including SOF) -> symbol sequence Z Z X X Y Z X Y Z Y. Each pause is 32 cycles, starting at cnt 0 (Z) or cnt 64 (X) plus 1 cycle. ssp_din then returns to 0.
- Single boundary tx_en pulse -> Z, then Z (EOF 0 after SOF), then Y, then IDLE.
- Frame of 0xFF (8 ones) -> Z then 8x X. EOF logic 0 after a one gives Y, then Y. ssp_frame is high at SOF and again 8 bit periods later.
- PAUSE_LEN=16 build, bit 1 -> pause_q high for cnt 65..80 only. Boundary values cnt 64 and 80 are checked.
- rst_n asserted at cnt=70 during an X pause -> pause_q and pwr_hi gating clear asynchronously. After release, state is IDLE and no symbols are emitted until the next tx_en.
